placar_registro_pontos: RTL
===========================

// Module: placar_registro_pontos
// PURPOSE
//  Sequential score store feeding the scoreboard adder/display stage: debounces raw
//  point buttons A/B/C, commits one +/- point event per press into the selected team's
//  7-bit score register, and drives N1-style current-score, limit LED, invalid LED, buzzer.
//  Sits directly upstream of the combinational add/subtract + 7-segment path.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000    clocks a raw button must be stable before debounced level changes
//  BUZZER_CYCLES    25000000  buzzer pulse length in clocks after a rejected add (limit hit)
//  MAX_SCORE        99        highest legal score per team
// PORTS
//  clock            in   1  system clock, rising edge
//  reset            in   1  asynchronous, active-high; clears all state
//  A, B, C          in   1  raw pushbuttons, active-high; A=1, B=2, C=3 points
//  ChaveNegativaPositiva in 1  0 = add, 1 = subtract (sampled at commit)
//  MudarTime        in   1  team select: 0 = team0, 1 = team1 (sampled at commit)
//  BtnUndo          in   1  raw undo button (used only with PLACAR_UNDO_EN)
//  pontos_time0     out  7  team0 registered score
//  pontos_time1     out  7  team1 registered score
//  N1               out  7  score of currently selected team (comb. mux of registers)
//  SaidaBtns        out  2  points value of last committed event (0 after reset)
//  commit           out  1  one-cycle pulse when a score register is written
//  led_invalido     out  1  held high after rejected subtract; cleared by next accepted commit
//  led_limite       out  1  held high after rejected add; cleared by next accepted commit
//  buzzer           out  1  high for BUZZER_CYCLES after rejected add
// BEHAVIOUR
//  - Reset: both scores 0, SaidaBtns 0, commit 0, both LEDs 0, buzzer 0, FSM IDLE,
//    debounced levels 0, counters 0. Reset mid-debounce or mid-buzz aborts immediately.
//  - Inputs double-flop synchronised; per-button counter restarts on any change of the
//    synced value; debounced level updates when counter reaches DEBOUNCE_CYCLES-1.
//  - FSM IDLE: on any debounced rising level (A/B/C) -> evaluate, go WAIT_RELEASE.
//    Simultaneous buttons: highest value wins (C > B > A).
//  - FSM WAIT_RELEASE: ignore all buttons; return IDLE when A, B, C debounced all 0.
//  - Evaluate (1 clock after debounced rise, registered): pts = 1/2/3.
//    Add: if score+pts <= MAX_SCORE write sum, else no write, led_limite=1, buzzer starts.
//    Subtract: if pts <= score write score-pts, else no write, led_invalido=1.
//    Accepted write: commit pulse, SaidaBtns=pts, both LEDs cleared.
//    Rejected: SaidaBtns=pts, no commit pulse.
//  - Arithmetic in 8 bits before compare; stored value never exceeds MAX_SCORE, never <0.
//  - Team/mode change while a button is held: no effect until next press commit.
//  - Buzzer retrigger while active restarts the count to full BUZZER_CYCLES.
// CONFIGURATION
//  PLACAR_UNDO_EN defined: 1-deep undo register holds {team, previous score} of last
//    accepted commit; debounced BtnUndo rise in IDLE restores it, pulses commit, clears
//    LEDs, invalidates undo slot (second undo does nothing). BtnUndo ignored in WAIT_RELEASE.
//  PLACAR_UNDO_EN undefined: BtnUndo unused, no undo storage synthesised.
// TESTING (DEBOUNCE_CYCLES=4, BUZZER_CYCLES=8, MAX_SCORE=99)
//  1. Reset, team0, add, hold C 10 clk -> pontos_time0=3, one commit pulse, N1=3.
//  2. Glitch A high 2 clk then low -> no commit, scores unchanged.
//  3. team1=98, add, press B -> rejected: pontos_time1=98, led_limite=1, buzzer high 8 clk.
//  4. team0=2, subtract, press C -> led_invalido=1, score 2; then press A -> score 1, LEDs 0.
//  5. A and C pressed same cycle, add, team0=0 -> pontos_time0=3 (C wins), single commit.
//  6. Assert reset mid-buzz and mid-hold -> all outputs 0 same cycle; undo (if EN): 5+2=7, undo -> 5.

Source files
------------

// File: rtl/placar_registro_pontos.sv
// Score register stage for the scoreboard. It debounces the A/B/C point buttons and
// commits one +/- event per press into the selected team's 7-bit score.
// It also drives the limit LED, the invalid LED and the buzzer.
// Optional feature: define PLACAR_UNDO_EN to add a 1-deep undo of the last accepted commit.
module placar_registro_pontos #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned BUZZER_CYCLES   = 25000000,
    parameter int unsigned MAX_SCORE       = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       ChaveNegativaPositiva,
    input  logic       MudarTime,
    input  logic       BtnUndo,
    output logic [6:0] pontos_time0,
    output logic [6:0] pontos_time1,
    output logic [6:0] N1,
    output logic [1:0] SaidaBtns,
    output logic       commit,
    output logic       led_invalido,
    output logic       led_limite,
    output logic       buzzer
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BW = $clog2(BUZZER_CYCLES + 1);

`ifdef PLACAR_UNDO_EN
    localparam int unsigned NB = 4;
    logic [NB-1:0] w_btn_raw;
    assign w_btn_raw = {BtnUndo, C, B, A};
`else
    localparam int unsigned NB = 3;
    logic [NB-1:0] w_btn_raw;
    logic          w_unused_undo;
    assign w_btn_raw     = {C, B, A};
    assign w_unused_undo = BtnUndo;
`endif

    typedef enum logic {StIdle, StWaitRelease} state_t;

    logic [NB-1:0] r_btn_s1, r_btn_s2, r_db;
    logic [DW-1:0] r_cnt [NB];
    logic [1:0]    r_sel_s1, r_sel_s2;   // {MudarTime, ChaveNegativaPositiva}
    state_t        r_state;
    logic [6:0]    r_p0, r_p1;
    logic [1:0]    r_saida;
    logic          r_commit, r_led_inv, r_led_lim, r_buzzer;
    logic [BW-1:0] r_buzz_cnt;

    logic       w_team, w_sub, w_any, w_add_ok, w_sub_ok, w_ok;
    logic [1:0] w_pts;
    logic [7:0] w_cur, w_sum, w_diff;
    logic [6:0] w_new;

    assign w_team   = r_sel_s2[1];
    assign w_sub    = r_sel_s2[0];
    assign w_any    = |r_db[2:0];
    // Priority encode so simultaneous presses score the highest value.
    assign w_pts    = r_db[2] ? 2'd3 : (r_db[1] ? 2'd2 : 2'd1);
    assign w_cur    = {1'b0, (w_team ? r_p1 : r_p0)};
    assign w_sum    = w_cur + {6'd0, w_pts};
    assign w_diff   = w_cur - {6'd0, w_pts};
    assign w_add_ok = (w_sum <= 8'(MAX_SCORE));
    assign w_sub_ok = ({6'd0, w_pts} <= w_cur);
    assign w_ok     = w_sub ? w_sub_ok : w_add_ok;
    assign w_new    = w_sub ? w_diff[6:0] : w_sum[6:0];

    assign pontos_time0 = r_p0;
    assign pontos_time1 = r_p1;
    assign N1           = w_team ? r_p1 : r_p0;
    assign SaidaBtns    = r_saida;
    assign commit       = r_commit;
    assign led_invalido = r_led_inv;
    assign led_limite   = r_led_lim;
    assign buzzer       = r_buzzer;

    // Two-flop synchronisers for buttons and the mode/team switches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sel_s1 <= '0;
            r_sel_s2 <= '0;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sel_s1 <= {MudarTime, ChaveNegativaPositiva};
            r_sel_s2 <= r_sel_s1;
        end
    end

    // Per-button debounce: count while synced level differs from debounced level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_db <= '0;
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_btn_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]  <= r_btn_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DW'(1);
                end
            end
        end
    end

`ifdef PLACAR_UNDO_EN
    logic       r_undo_prev, r_undo_valid, r_undo_team;
    logic [6:0] r_undo_score;
    logic       w_undo_rise;
    assign w_undo_rise = r_db[3] & ~r_undo_prev;
`endif

    // Press FSM, score registers, LEDs and buzzer timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_p0       <= '0;
            r_p1       <= '0;
            r_saida    <= '0;
            r_commit   <= 1'b0;
            r_led_inv  <= 1'b0;
            r_led_lim  <= 1'b0;
            r_buzzer   <= 1'b0;
            r_buzz_cnt <= '0;
`ifdef PLACAR_UNDO_EN
            r_undo_prev  <= 1'b0;
            r_undo_valid <= 1'b0;
            r_undo_team  <= 1'b0;
            r_undo_score <= '0;
`endif
        end else begin
            r_commit <= 1'b0;
`ifdef PLACAR_UNDO_EN
            // Tracked in every state so a rise during WAIT_RELEASE is consumed, not deferred.
            r_undo_prev <= r_db[3];
`endif
            if (r_buzzer) begin
                if (r_buzz_cnt == '0) r_buzzer   <= 1'b0;
                else                  r_buzz_cnt <= r_buzz_cnt - BW'(1);
            end
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state <= StWaitRelease;
                        r_saida <= w_pts;
                        if (w_ok) begin
                            if (w_team) r_p1 <= w_new;
                            else        r_p0 <= w_new;
                            r_commit  <= 1'b1;
                            r_led_inv <= 1'b0;
                            r_led_lim <= 1'b0;
`ifdef PLACAR_UNDO_EN
                            r_undo_valid <= 1'b1;
                            r_undo_team  <= w_team;
                            r_undo_score <= w_cur[6:0];
`endif
                        end else if (w_sub) begin
                            r_led_inv <= 1'b1;
                        end else begin
                            // Later assignment overrides the countdown: retrigger restarts.
                            r_led_lim  <= 1'b1;
                            r_buzzer   <= 1'b1;
                            r_buzz_cnt <= BW'(BUZZER_CYCLES - 1);
                        end
                    end
`ifdef PLACAR_UNDO_EN
                    else if (w_undo_rise && r_undo_valid) begin
                        if (r_undo_team) r_p1 <= r_undo_score;
                        else             r_p0 <= r_undo_score;
                        r_commit     <= 1'b1;
                        r_led_inv    <= 1'b0;
                        r_led_lim    <= 1'b0;
                        r_undo_valid <= 1'b0;
                    end
`endif
                end
                StWaitRelease: begin
                    if (!w_any) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
